x_pulse_gen: RTL and testbench

- Transmitter end of the single-bit "x" pulse interface consumed by the team's mod-4 pulse-counting Moore detector.
- Emits a burst of N single-cycle x pulses with a programmable idle gap between pulses, under a start/ready/done handshake.
- Maintains a mirror of the detector's mod-4 phase, so the testbench and system can predict the detector's out without probing it.
- Sits upstream of the detector on the same clock.

---
 rtl/x_pulse_pkg.sv | 14 +
 rtl/x_gap_timer.sv | 28 ++
 rtl/x_pulse_gen.sv | 141 ++++++++++++++
 tb/tb_x_pulse_gen.sv | 210 +++++++++++++++++++++
 4 files changed

// File: rtl/x_pulse_pkg.sv
// Shared types and constants for the x pulse generator and its gap timer.
package x_pulse_pkg;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        PULSE = 2'd1,
        GAP   = 2'd2,
        DONE  = 2'd3
    } state_t;

    localparam int PHASE_W = 2;
    localparam logic [PHASE_W-1:0] PHASE_HIT_VAL = 2'd3;

endpackage

// File: rtl/x_gap_timer.sv
// Loadable down-counter timing the idle cycles between x pulses.
module x_gap_timer #(
    parameter int GAP_W = 4
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             load,
    input  logic [GAP_W-1:0] value,
    input  logic             enable,
    output logic             expired
);

    logic [GAP_W-1:0] r_cnt;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_cnt <= '0;
        end else if (load) begin
            r_cnt <= value;
        end else if (enable && (r_cnt != '0)) begin
            r_cnt <= r_cnt - GAP_W'(1);
        end
    end

    // Expiry fires on the last enabled cycle, so a load of N gives N enabled cycles.
    assign expired = enable && (r_cnt == GAP_W'(1));

endmodule

// File: rtl/x_pulse_gen.sv
// Burst generator for the single-bit x pulse line, with a mirror of the detector's mod-4 phase.
// Optional abort input enabled by defining X_PULSE_GEN_ABORT_EN.
module x_pulse_gen
    import x_pulse_pkg::*;
#(
    parameter int CNT_W = 8,
    parameter int GAP_W = 4
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             start,
    input  logic [CNT_W-1:0] count,
    input  logic [GAP_W-1:0] gap,
`ifdef X_PULSE_GEN_ABORT_EN
    input  logic             abort,
`endif
    output logic             ready,
    output logic             busy,
    output logic             x,
    output logic             done,
    output logic [1:0]       phase,
    output logic             phase_hit,
    output logic [1:0]       dbg_state
);

    state_t             r_state;
    state_t             w_state_nxt;
    logic [CNT_W-1:0]   r_remain;
    logic [CNT_W-1:0]   w_remain_nxt;
    logic [GAP_W-1:0]   r_gap;
    logic [PHASE_W-1:0] r_phase;
    logic [PHASE_W-1:0] w_phase_nxt;
    logic               r_x;
    logic               r_busy;
    logic               r_ready;
    logic               r_done;
    logic               r_phase_hit;
    logic               w_accept;
    logic               w_tmr_load;
    logic               w_tmr_en;
    logic               w_tmr_expired;
    logic               w_abort;

`ifdef X_PULSE_GEN_ABORT_EN
    assign w_abort = abort;
`else
    assign w_abort = 1'b0;
`endif

    x_gap_timer #(
        .GAP_W (GAP_W)
    ) u_gap_timer (
        .clk     (clk),
        .rst_n   (rst_n),
        .load    (w_tmr_load),
        .value   (r_gap),
        .enable  (w_tmr_en),
        .expired (w_tmr_expired)
    );

    always_comb begin
        w_state_nxt  = r_state;
        w_remain_nxt = r_remain;
        w_phase_nxt  = r_phase;
        w_accept     = 1'b0;
        w_tmr_load   = 1'b0;
        w_tmr_en     = 1'b0;
        case (r_state)
            IDLE: begin
                if (start) begin
                    w_accept     = 1'b1;
                    w_remain_nxt = count;
                    w_state_nxt  = (count == '0) ? DONE : PULSE;
                end
            end
            PULSE: begin
                // The pulse on the line this cycle always counts, even when aborted.
                w_phase_nxt  = r_phase + PHASE_W'(1);
                w_remain_nxt = r_remain - CNT_W'(1);
                if (w_abort || (r_remain == CNT_W'(1))) begin
                    w_state_nxt = DONE;
                end else if (r_gap == '0) begin
                    w_state_nxt = PULSE;
                end else begin
                    w_state_nxt = GAP;
                    w_tmr_load  = 1'b1;
                end
            end
            GAP: begin
                w_tmr_en = 1'b1;
                if (w_abort) begin
                    w_state_nxt = DONE;
                end else if (w_tmr_expired) begin
                    w_state_nxt = PULSE;
                end
            end
            DONE: begin
                w_state_nxt = IDLE;
            end
            default: begin
                w_state_nxt = IDLE;
            end
        endcase
    end

    // Outputs are registered from the next state so they equal a Moore decode of r_state.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state     <= IDLE;
            r_remain    <= '0;
            r_gap       <= '0;
            r_phase     <= '0;
            r_phase_hit <= 1'b0;
            r_x         <= 1'b0;
            r_busy      <= 1'b0;
            r_ready     <= 1'b1;
            r_done      <= 1'b0;
        end else begin
            r_state     <= w_state_nxt;
            r_remain    <= w_remain_nxt;
            if (w_accept) begin
                r_gap <= gap;
            end
            r_phase     <= w_phase_nxt;
            r_phase_hit <= (w_phase_nxt == PHASE_HIT_VAL);
            r_x         <= (w_state_nxt == PULSE);
            r_busy      <= (w_state_nxt == PULSE) || (w_state_nxt == GAP);
            r_ready     <= (w_state_nxt == IDLE);
            r_done      <= (w_state_nxt == DONE);
        end
    end

    assign ready     = r_ready;
    assign busy      = r_busy;
    assign x         = r_x;
    assign done      = r_done;
    assign phase     = r_phase;
    assign phase_hit = r_phase_hit;
    assign dbg_state = r_state;

endmodule

// File: tb/tb_x_pulse_gen.sv
// Bench for x_pulse_gen: scoreboarded bursts plus a mod-4 pulse-counting detector model.
module tb_x_pulse_gen;

    localparam int W = 7;

    logic       clk = 1'b0;
    logic       rst_n = 1'b1;
    logic       start = 1'b0;
    logic       abort = 1'b0;
    logic [7:0] count = '0;
    logic [3:0] gap = '0;
    logic       ready, busy, x, done, phase_hit;
    logic [1:0] phase, dbg_state;

    logic [1:0]   det_cnt;
    logic         det_out;
    logic [W-1:0] exp_q[$];
    logic [1:0]   m_phase = 2'd0;
    int           checks = 0;
    int           failures = 0;

    x_pulse_gen #(.CNT_W(8), .GAP_W(4)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .start     (start),
        .count     (count),
        .gap       (gap),
`ifdef X_PULSE_GEN_ABORT_EN
        .abort     (abort),
`endif
        .ready     (ready),
        .busy      (busy),
        .x         (x),
        .done      (done),
        .phase     (phase),
        .phase_hit (phase_hit),
        .dbg_state (dbg_state)
    );

    always #5 clk = ~clk;

    // Reference detector: counts x pulses mod 4, out high in state 3.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) det_cnt <= 2'd0;
        else if (x) det_cnt <= det_cnt + 2'd1;
    end
    assign det_out = (det_cnt == 2'd3);

    function automatic logic [W-1:0] mk(input logic rdy, input logic bsy, input logic xx,
                                         input logic dn, input logic [1:0] ph);
        return {rdy, bsy, xx, dn, (ph == 2'd3), ph};
    endfunction

    task automatic run_burst(input int n, input int g, input bit noise, input int abort_idx,
                             input string name);
        logic [W-1:0] e, obs;
        int cyc, total;
        bit stop;
        cyc = 0;
        stop = 0;
        exp_q.delete();
        for (int i = 0; i < n && !stop; i++) begin
            exp_q.push_back(mk(1'b0, 1'b1, 1'b1, 1'b0, m_phase));
            m_phase = m_phase + 2'd1;
            if (cyc == abort_idx) stop = 1;
            cyc++;
            for (int j = 0; j < g && i < n - 1 && !stop; j++) begin
                exp_q.push_back(mk(1'b0, 1'b1, 1'b0, 1'b0, m_phase));
                if (cyc == abort_idx) stop = 1;
                cyc++;
            end
        end
        exp_q.push_back(mk(1'b0, 1'b0, 1'b0, 1'b1, m_phase));
        @(negedge clk);
        start = 1'b1;
        count = n[7:0];
        gap   = g[3:0];
        total = exp_q.size();
        for (int k = 0; k < total; k++) begin
            @(negedge clk);
            e   = exp_q.pop_front();
            obs = {ready, busy, x, done, phase_hit, phase};
            checks++;
            if (obs !== e) begin
                failures++;
                $display("FAIL %s cyc=%0d {rdy,bsy,x,done,hit,ph} got=%b want=%b", name, k, obs, e);
            end
            checks++;
            if ({det_out, det_cnt} !== {phase_hit, phase}) begin
                failures++;
                $display("FAIL %s_detector cyc=%0d dut={hit,ph}=%b det={out,st}=%b",
                         name, k, {phase_hit, phase}, {det_out, det_cnt});
            end
            if (noise && k < total - 1) begin
                start = 1'b1;
                count = 8'($urandom_range(1, 255));
                gap   = 4'($urandom_range(0, 15));
            end else begin
                start = 1'b0;
            end
            abort = (k == abort_idx);
        end
        start = 1'b0;
        abort = 1'b0;
    endtask

    task automatic test_reset();
        logic [W-1:0] obs;
        #1 rst_n = 1'b0;
        #2;
        obs = {ready, busy, x, done, phase_hit, phase};
        checks++;
        if (obs !== mk(1'b1, 1'b0, 1'b0, 1'b0, 2'd0)) begin
            failures++;
            $display("FAIL reset_async got=%b want=%b", obs, mk(1'b1, 1'b0, 1'b0, 1'b0, 2'd0));
        end
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        m_phase = 2'd0;
        for (int k = 0; k < 5; k++) begin
            @(negedge clk);
            obs = {ready, busy, x, done, phase_hit, phase};
            checks++;
            if (obs !== mk(1'b1, 1'b0, 1'b0, 1'b0, 2'd0)) begin
                failures++;
                $display("FAIL reset_idle cyc=%0d got=%b want=%b", k, obs,
                         mk(1'b1, 1'b0, 1'b0, 1'b0, 2'd0));
            end
        end
    endtask

    task automatic test_burst_gap();
        run_burst(3, 2, 1'b0, -1, "burst_c3_g2");
    endtask

    task automatic test_back_to_back();
        run_burst(4, 0, 1'b0, -1, "b2b_c4_g0");
    endtask

    task automatic test_zero_count();
        run_burst(0, 7, 1'b0, -1, "zero_count");
    endtask

    task automatic test_start_ignored();
        run_burst(5, 1, 1'b1, -1, "start_ignored_c5");
    endtask

    task automatic test_random();
        for (int r = 0; r < 8; r++) begin
            run_burst(int'($urandom_range(1, 20)), int'($urandom_range(0, 15)),
                      1'($urandom_range(0, 1)), -1, "random");
        end
    endtask

    task automatic test_reset_mid_burst();
        logic [W-1:0] obs;
        @(negedge clk);
        start = 1'b1;
        count = 8'd5;
        gap   = 4'd0;
        @(negedge clk);
        start = 1'b0;
        @(posedge clk);
        #2 rst_n = 1'b0;
        #1;
        obs = {ready, busy, x, done, phase_hit, phase};
        checks++;
        if ({obs, det_out, det_cnt} !== {mk(1'b1, 1'b0, 1'b0, 1'b0, 2'd0), 3'b000}) begin
            failures++;
            $display("FAIL reset_mid_burst got=%b det=%b want=%b det=000", obs,
                     {det_out, det_cnt}, mk(1'b1, 1'b0, 1'b0, 1'b0, 2'd0));
        end
        @(negedge clk);
        rst_n = 1'b1;
        m_phase = 2'd0;
        for (int k = 0; k < 5; k++) begin
            @(negedge clk);
            obs = {ready, busy, x, done, phase_hit, phase};
            checks++;
            if (obs !== mk(1'b1, 1'b0, 1'b0, 1'b0, 2'd0)) begin
                failures++;
                $display("FAIL reset_mid_burst_after cyc=%0d got=%b want=%b", k, obs,
                         mk(1'b1, 1'b0, 1'b0, 1'b0, 2'd0));
            end
        end
    endtask

`ifdef X_PULSE_GEN_ABORT_EN
    task automatic test_abort();
        // Cycle 5 of a count=10, gap=1 burst is the third GAP.
        run_burst(10, 1, 1'b0, 5, "abort_third_gap");
    endtask
`endif

    initial begin
        test_reset();
        test_burst_gap();
        test_back_to_back();
        test_zero_count();
        test_start_ignored();
        test_random();
        test_reset_mid_burst();
`ifdef X_PULSE_GEN_ABORT_EN
        test_abort();
`endif
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
